// File: rtl/mmio_port_bank.sv
// Memory-mapped port bank: output registers, synchronised inputs, sticky
// rising-edge status with write-1-to-clear, per-bit masks and one interrupt.
module mmio_port_bank #(
  parameter  int NUM_PORTS   = 8,
  parameter  int DATA_WIDTH  = 32,
  parameter  int SYNC_STAGES = 2,
  localparam int PORT_BITS   = $clog2(NUM_PORTS)
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic [PORT_BITS+1:0]                  backendAddress,
  output logic [DATA_WIDTH-1:0]                 mmioDataOut,
  input  logic [DATA_WIDTH-1:0]                 wdata,
  input  logic [DATA_WIDTH/8-1:0]               byteWriteEnable,
  input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  mmioInputs,
  output logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  mmioOutputs,
  output logic                                  interrupt
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int ARM_W = $clog2(SYNC_STAGES + 2);
  localparam logic [ARM_W-1:0] ARM_DONE = ARM_W'(SYNC_STAGES + 1);

  localparam logic [1:0] REG_IN     = 2'd0;
  localparam logic [1:0] REG_OUT    = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_MASK   = 2'd3;

  function automatic logic [DATA_WIDTH-1:0] byte_mask(input logic [BYTES-1:0] be);
    logic [DATA_WIDTH-1:0] m;
    m = '0;
    for (int b = 0; b < BYTES; b++)
      if (be[b]) m[8*b +: 8] = 8'hFF;
    return m;
  endfunction

  logic [1:0]                                  region;
  logic [PORT_BITS-1:0]                        port;
  logic [DATA_WIDTH-1:0]                       wmask;
  logic [DATA_WIDTH-1:0]                       wbits;
  logic                                        wr_any;

  logic [SYNC_STAGES-1:0][NUM_PORTS-1:0][DATA_WIDTH-1:0] sync_q;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]        sync_out;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]        prev_q;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]        edge_d;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]        out_q;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]        mask_q;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]        status_q;
  logic [ARM_W-1:0]                            arm_cnt;
  logic                                        armed;
  logic                                        irq_q;

  assign region   = backendAddress[PORT_BITS+1:PORT_BITS];
  assign port     = backendAddress[PORT_BITS-1:0];
  assign wmask    = byte_mask(byteWriteEnable);
  assign wbits    = wdata & wmask;
  assign wr_any   = |byteWriteEnable;
  assign sync_out = sync_q[SYNC_STAGES-1];

  // input synchroniser chain
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= mmioInputs;
      for (int s = 1; s < SYNC_STAGES; s++)
        sync_q[s] <= sync_q[s-1];
      prev_q <= sync_out;
    end
  end

  // Arming holds edge detection off until prev_q has seen real synchronised
  // data, so pins already high at reset release do not look like edges.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      arm_cnt <= '0;
    else if (!armed)
      arm_cnt <= arm_cnt + ARM_W'(1);
  end

  assign armed  = (arm_cnt == ARM_DONE);
  assign edge_d = armed ? (sync_out & ~prev_q) : '0;

  // register file: outputs, masks, sticky status
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_q    <= '0;
      mask_q   <= '0;
      status_q <= '0;
    end else begin
      if (wr_any && region == REG_OUT)
        out_q[port] <= (out_q[port] & ~wmask) | wbits;
      if (wr_any && region == REG_MASK)
        mask_q[port] <= (mask_q[port] & ~wmask) | wbits;
      // OR-ing the new edge in after the clear lets a coincident set win
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (wr_any && region == REG_STATUS && port == PORT_BITS'(p))
          status_q[p] <= (status_q[p] & ~wbits) | edge_d[p];
        else
          status_q[p] <= status_q[p] | edge_d[p];
      end
    end
  end

  // interrupt output stage
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      irq_q <= 1'b0;
    else
      irq_q <= |(status_q & mask_q);
  end

  always_comb begin
    mmioDataOut = '0;
    case (region)
      REG_IN:     mmioDataOut = sync_out[port];
      REG_OUT:    mmioDataOut = out_q[port];
      REG_STATUS: mmioDataOut = status_q[port];
      REG_MASK:   mmioDataOut = mask_q[port];
      default:    mmioDataOut = '0;
    endcase
  end

  assign mmioOutputs = out_q;
  assign interrupt   = irq_q;

endmodule

// File: tb/tb_mmio_port_bank.sv
// Bench for mmio_port_bank: directed vector table, hand-built timing
// sequences and randomized traffic against a history-based reference model.
module tb_mmio_port_bank;
  localparam int NP = 8;
  localparam int DW = 32;
  localparam int SS = 2;
  localparam int PB = 3;
  localparam int NB = DW / 8;

  logic                   clock = 1'b0;
  logic                   reset;
  logic [PB+1:0]          backendAddress;
  logic [DW-1:0]          mmioDataOut;
  logic [DW-1:0]          wdata;
  logic [NB-1:0]          byteWriteEnable;
  logic [NP-1:0][DW-1:0]  mmioInputs;
  logic [NP-1:0][DW-1:0]  mmioOutputs;
  logic                   interrupt;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  mmio_port_bank #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .SYNC_STAGES(SS)) dut (
    .clock(clock),
    .reset(reset),
    .backendAddress(backendAddress),
    .mmioDataOut(mmioDataOut),
    .wdata(wdata),
    .byteWriteEnable(byteWriteEnable),
    .mmioInputs(mmioInputs),
    .mmioOutputs(mmioOutputs),
    .interrupt(interrupt)
  );

  // Reference model: register contents plus the list of input snapshots
  // taken at each clock edge since reset release.
  logic [DW-1:0]          out_m [NP];
  logic [DW-1:0]          mask_m[NP];
  logic [DW-1:0]          st_m  [NP];
  logic                   int_m;
  logic [NP-1:0][DW-1:0]  hist[$];
  int                     nedges;

  function automatic logic [NP-1:0][DW-1:0] seen(int ago);
    if (hist.size() < ago) return '0;
    return hist[hist.size() - ago];
  endfunction

  function automatic logic [DW-1:0] model_read(logic [1:0] r, int p);
    logic [NP-1:0][DW-1:0] s;
    s = seen(SS);
    case (r)
      2'd0: return s[p];
      2'd1: return out_m[p];
      2'd2: return st_m[p];
      default: return mask_m[p];
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NP; i++) begin
      out_m[i] = '0; mask_m[i] = '0; st_m[i] = '0;
    end
    int_m = 1'b0;
    hist.delete();
    nedges = 0;
  endtask

  task automatic model_edge();
    logic [NP-1:0][DW-1:0] s, pv;
    logic [DW-1:0] bm, w;
    logic any;
    int pt;
    s = seen(SS);
    pv = seen(SS + 1);
    any = 1'b0;
    for (int i = 0; i < NP; i++) any |= |(st_m[i] & mask_m[i]);
    bm = '0;
    for (int b = 0; b < NB; b++) if (byteWriteEnable[b]) bm[8*b +: 8] = 8'hFF;
    w = wdata & bm;
    pt = int'(backendAddress[PB-1:0]);
    case (backendAddress[PB+1:PB])
      2'd1: out_m[pt]  = (out_m[pt] & ~bm) | w;
      2'd2: st_m[pt]   = st_m[pt] & ~w;
      2'd3: mask_m[pt] = (mask_m[pt] & ~bm) | w;
      default: ;
    endcase
    if (nedges >= SS + 1)
      for (int i = 0; i < NP; i++) st_m[i] |= s[i] & ~pv[i];
    int_m = any;
    hist.push_back(mmioInputs);
    if (hist.size() > SS + 1) void'(hist.pop_front());
    nedges++;
  endtask

  task automatic chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic compare_all();
    for (int p = 0; p < NP; p++)
      chk($sformatf("out%0d", p), mmioOutputs[p], out_m[p]);
    chk("irq", DW'(interrupt), DW'(int_m));
    chk("rdata", mmioDataOut,
        model_read(backendAddress[PB+1:PB], int'(backendAddress[PB-1:0])));
  endtask

  task automatic tick();
    model_edge();
    @(posedge clock);
    #1;
    compare_all();
  endtask

  task automatic set_addr(logic [1:0] r, int p);
    backendAddress = {r, PB'(p)};
  endtask

  task automatic do_reset();
    reset = 1'b0;
    byteWriteEnable = '0;
    model_reset();
    @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  typedef struct {
    logic [1:0]    region;
    logic [PB-1:0] port;
    logic [DW-1:0] wd;
    logic [NB-1:0] be;
    logic [DW-1:0] exp;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{2'd1, 3'd3, 32'hDEADBEEF, 4'hF, 32'hDEADBEEF};
    vecs[1] = '{2'd1, 3'd3, 32'h11223344, 4'h5, 32'hDE22BE44};
    vecs[2] = '{2'd3, 3'd5, 32'h00000001, 4'hF, 32'h00000001};
    vecs[3] = '{2'd1, 3'd0, 32'hA5A5A5A5, 4'h8, 32'hA5000000};
    vecs[4] = '{2'd0, 3'd2, 32'hFFFFFFFF, 4'hF, 32'h00000000};
    vecs[5] = '{2'd3, 3'd7, 32'h1234ABCD, 4'h3, 32'h0000ABCD};
    vecs[6] = '{2'd1, 3'd3, 32'h00000000, 4'h0, 32'hDE22BE44};
    vecs[7] = '{2'd2, 3'd1, 32'hFFFFFFFF, 4'hF, 32'h00000000};

    reset = 1'b0;
    backendAddress = '0;
    wdata = '0;
    byteWriteEnable = '0;
    mmioInputs = '0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    chk("rst_irq", DW'(interrupt), '0);
    for (int r = 0; r < 4; r++)
      for (int p = 0; p < NP; p++) begin
        set_addr(2'(r), p);
        #1;
        chk($sformatf("rst_out%0d", p), mmioOutputs[p], '0);
        chk($sformatf("rst_rd_r%0d_p%0d", r, p), mmioDataOut, '0);
      end
    @(posedge clock);
    #1;
    reset = 1'b1;

    // directed vector table
    for (int i = 0; i < 8; i++) begin
      backendAddress = {vecs[i].region, vecs[i].port};
      wdata = vecs[i].wd;
      byteWriteEnable = vecs[i].be;
      tick();
      byteWriteEnable = '0;
      #1;
      chk($sformatf("vec%0d_rd", i), mmioDataOut, vecs[i].exp);
      if (i == 0)
        for (int p = 0; p < NP; p++)
          if (p != 3) chk($sformatf("vec0_other%0d", p), mmioOutputs[p], '0);
    end
    chk("vec_port3", mmioOutputs[3], 32'hDE22BE44);

    // input sync latency, status set and interrupt rise
    set_addr(2'd0, 5);
    mmioInputs[5] = 32'h1;
    tick();
    chk("sync_edge1", mmioDataOut, 32'h0);
    tick();
    chk("sync_edge2", mmioDataOut, 32'h1);
    set_addr(2'd2, 5);
    #1;
    chk("status_pre", mmioDataOut, 32'h0);
    tick();
    chk("status_edge3", mmioDataOut, 32'h1);
    chk("irq_edge3", DW'(interrupt), 32'h0);
    tick();
    chk("irq_edge4", DW'(interrupt), 32'h1);

    // write-1-to-clear and interrupt fall
    wdata = 32'h1;
    byteWriteEnable = 4'hF;
    tick();
    byteWriteEnable = '0;
    chk("w1c_status", mmioDataOut, 32'h0);
    chk("w1c_irq_hold", DW'(interrupt), 32'h1);
    tick();
    chk("w1c_irq_fall", DW'(interrupt), 32'h0);
    mmioInputs[5] = 32'h0;
    repeat (4) tick();
    mmioInputs[5] = 32'h1;
    repeat (SS) tick();
    wdata = 32'h1;
    byteWriteEnable = 4'hF;
    tick();
    byteWriteEnable = '0;
    chk("set_beats_w1c", mmioDataOut, 32'h1);
    tick();
    chk("set_beats_w1c_irq", DW'(interrupt), 32'h1);

    // pin held high through reset release
    mmioInputs = '0;
    mmioInputs[0] = 32'hFFFFFFFF;
    do_reset();
    tick();
    set_addr(2'd3, 0);
    wdata = 32'hFFFFFFFF;
    byteWriteEnable = 4'hF;
    tick();
    byteWriteEnable = '0;
    set_addr(2'd2, 0);
    repeat (5) tick();
    chk("held_status", mmioDataOut, 32'h0);
    chk("held_irq", DW'(interrupt), 32'h0);
    mmioInputs[0] = 32'h0;
    repeat (4) tick();
    mmioInputs[0] = 32'hFFFFFFFF;
    repeat (SS + 1) tick();
    chk("rearm_status", mmioDataOut, 32'hFFFFFFFF);
    tick();
    chk("rearm_irq", DW'(interrupt), 32'h1);

    // asynchronous reset in the middle of a write
    set_addr(2'd1, 2);
    wdata = 32'h12345678;
    byteWriteEnable = 4'hF;
    tick();
    chk("pre_rst_out2", mmioOutputs[2], 32'h12345678);
    chk("pre_rst_irq", DW'(interrupt), 32'h1);
    wdata = 32'hCAFEF00D;
    #2;
    reset = 1'b0;
    #1;
    for (int p = 0; p < NP; p++)
      chk($sformatf("arst_out%0d", p), mmioOutputs[p], '0);
    chk("arst_irq", DW'(interrupt), '0);
    chk("arst_rd", mmioDataOut, '0);
    model_reset();
    @(posedge clock);
    #1;
    byteWriteEnable = '0;
    chk("arst_write_lost", mmioOutputs[2], '0);
    reset = 1'b1;
    mmioInputs = '0;
    repeat (2) tick();

    // randomized traffic against the model
    do_reset();
    for (int n = 0; n < 400; n++) begin
      set_addr(2'($urandom_range(0, 3)), int'($urandom_range(0, NP - 1)));
      wdata = $urandom;
      byteWriteEnable = ($urandom_range(0, 1) == 1) ? NB'($urandom) : '0;
      for (int p = 0; p < NP; p++)
        if ($urandom_range(0, 3) == 0) mmioInputs[p] = $urandom;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mmio_port_bank.md
Name: mmio_port_bank

Overview:
Parametrised successor to the core's 8-port memory-mapped I/O block. It sits behind the MemoryBackend on the top word addresses and provides NUM_PORTS output registers (readable, byte-strobed writes), input ports with synchronisers, sticky rising-edge status bits with write-1-to-clear, per-bit interrupt masks and a single registered interrupt line. Reads are combinational with the same timing as existing MMIO; writes commit on the clock edge.

Parameters:
NUM_PORTS, 8, number of input and output ports; power of 2, 2..64
DATA_WIDTH, 32, port width in bits; multiple of 8
SYNC_STAGES, 2, input synchroniser depth; 2..4
PORT_BITS, $clog2(NUM_PORTS), derived; not to be overridden

Ports:
clock  in  1  single clock; all state is on its rising edge
reset  in  1  asynchronous, active-low reset; reset active while 0
backendAddress  in  PORT_BITS+2  word address within bank; [PORT_BITS+1:PORT_BITS]=region, [PORT_BITS-1:0]=port index
mmioDataOut  out  DATA_WIDTH  combinational read data
wdata  in  DATA_WIDTH  write data (rs2)
byteWriteEnable  in  DATA_WIDTH/8  per-byte write strobes; all-zero = no write
mmioInputs  in  NUM_PORTS x DATA_WIDTH  asynchronous external inputs
mmioOutputs  out  NUM_PORTS x DATA_WIDTH  registered outputs
interrupt  out  1  registered OR of (status & mask)

Behaviour:
- Regions: 0 = input data (RO, synchronised), 1 = output data (RW), 2 = edge status (R/W1C), 3 = interrupt mask (RW).
- Reset (reset=0, async): all mmioOutputs, status, mask, synchroniser and previous-value flops = 0; interrupt = 0; arm counter = 0.
- Read: mmioDataOut = selected region[port] same cycle; no side effects (status is not clear-on-read).
- Write, region 1/3: for each byte b with byteWriteEnable[b]=1, reg[port][8b+7:8b] <= wdata byte b; other bytes hold. Visible on mmioOutputs/readback the cycle after the edge.
- Write, region 2: status[port] <= status[port] & ~(wdata masked by byte strobes) | edge[port].
- Write, region 0: ignored, no state change.
- Input path: each bit passes SYNC_STAGES flops. A pin change set up before edge 1 is readable after edge SYNC_STAGES.
- Edge detect: prev <= sync_out every cycle; edge = sync_out & ~prev & armed. status |= edge.
- Arming: after reset release a counter counts SYNC_STAGES+1 edges, then armed=1 permanently until the next reset. Inputs already high at reset release set no status bit.
- Same-cycle set and W1C on the same bit: the set wins, and the bit stays 1.
- interrupt <= |(status & mask) over all ports and bits. It rises one cycle after status or mask makes the term true and falls one cycle after it clears.
- Reset asserted mid-write: the write is lost and all state returns to reset values immediately.
- An out-of-range port index cannot occur, because NUM_PORTS is a power of 2.

Test Plan:
1. Reset → all mmioOutputs=0, interrupt=0, every region reads 0. Write 0xDEADBEEF to region1 port3 with byteWriteEnable=4'b1111 → mmioOutputs[3]=0xDEADBEEF next cycle and reads back as the same value; other ports stay 0.
2. Port3 holds 0xDEADBEEF; write 0x11223344 with byteWriteEnable=4'b0101 → port3=0xDE22BE44.
3. Drive mmioInputs[5]=0x00000001 after arming (SYNC_STAGES=2) → region0 port5 reads 1 after edge 2; status port5=0x1 after edge 3; with mask port5=0x1 set beforehand, interrupt=1 after edge 4.
4. Status port5=0x1; write region2 port5 wdata=0x1 → status=0 and interrupt falls the next cycle. Repeat with a new rising edge in the same cycle as the W1C → status stays 0x1.
5. Hold mmioInputs[0]=0xFFFFFFFF through reset release → status port0 stays 0 and interrupt stays 0. Drop the input to 0, then raise it → status port0=0xFFFFFFFF.
6. Assert reset mid-operation with outputs, status and mask non-zero → every output and interrupt go to 0 asynchronously, before the next clock edge.
